kernel_nios2_cpu_mul_combine: RTL
=================================

// Module: kernel_nios2_cpu_mul_combine
// PURPOSE
//  Consumes the three registered 16x16 partial products from the multiplier cell:
//   p1 = a.lo*b.lo, p2 = a.lo*b.hi, p3 = a.hi*b.lo.
//  Combines them into the 32-bit low word of a*b, which is the same for signed and unsigned operands.
//  Delivers the result and its destination tag to writeback over a valid/ready handshake.
//  Sits directly downstream of the mult cell, between the M stage and the register-file write port.
// PARAMETERS
//  TAG_W  5   width of destination-register tag carried alongside each product
//  CNT_W  16  width of completed-multiply counter
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous reset, active low
//  in_valid    in   1      p1/p2/p3/in_tag hold a valid product set
//  in_ready    out  1      block accepts the set this cycle
//  in_p1       in   32     partial product a.lo*b.lo
//  in_p2       in   32     partial product a.lo*b.hi
//  in_p3       in   32     partial product a.hi*b.lo
//  in_tag      in   TAG_W  destination register index
//  flush       in   1      pipeline kill (exception/branch mispredict)
//  out_valid   out  1      out_result/out_tag valid
//  out_ready   in   1      writeback consumes the result this cycle
//  out_result  out  32     (a*b)[31:0]
//  out_tag     out  TAG_W  tag of out_result
//  busy        out  1      any stage holds a valid entry
//  mul_count   out  CNT_W  number of completed results (out_valid & out_ready)
// BEHAVIOUR
//  - Arithmetic: cross = p2[15:0] + p3[15:0], truncated to 16 bits.
//    result = p1 + {cross, 16'h0}, modulo 2^32.
//    p2[31:16] and p3[31:16] are ignored.
//  - Transfer in: occurs on in_valid & in_ready. Transfer out: occurs on out_valid & out_ready.
//  - Single-stage (default): output register loads on an input transfer.
//    in_ready = ~out_valid | out_ready. Latency 1 cycle; full throughput with out_ready held high.
//  - Handshake rules:
//    out_valid stays set and out_result/out_tag stay stable until the output transfer.
//    in_ready may depend combinationally on out_ready. No combinational path from in_valid to out_valid.
//    Simultaneous in and out transfer: the new entry replaces the old one; out_valid stays 1.
//  - flush: clears every valid bit on the next clock edge and overrides a same-cycle input transfer
//    (that entry is dropped). Data registers are don't-care after flush. mul_count is not incremented
//    by flush and is not cleared by it.
//  - mul_count increments on each output transfer. It wraps from all-ones to 0 with no flag.
//  - busy = OR of all stage valid bits.
//  - Reset (async assert, sync-released by top level): out_valid=0, out_result=0, out_tag=0,
//    mul_count=0, internal valids=0.
//    in_ready=1 during and after reset. Reset mid-operation discards all in-flight entries.
// CONFIGURATION
//  - MUL_COMBINE_PIPE_EN defined: adds stage A (register cross, p1, tag, valid_a) ahead of the
//    output stage B.
//    Latency 2 cycles; each stage is elastic: ready_a = ~valid_a | ready_b, ready_b = ~out_valid | out_ready.
//    Full throughput when out_ready=1. With out_ready=0 the block holds up to 2 entries, then drops in_ready.
//    flush clears valid_a and out_valid together.
//  - MUL_COMBINE_PIPE_EN undefined: single-stage behaviour as above.
// TESTING (run each in both configurations; latency L = 1 or 2)
//  1. p1=0x00000008, p2=0x0000000A, p3=0x0000000C, tag=3
//     -> out_result=0x00160008, out_tag=3, exactly L cycles after the input transfer.
//  2. p1=p2=p3=0xFFFE0001 (-1*-1) -> out_result=0x00000001.
//     p2[31:16]=0xABCD variant -> same result.
//  3. 8 back-to-back inputs with out_ready=1 -> 8 results in order on consecutive cycles;
//     in_ready never low; mul_count=8.
//  4. out_ready=0, stream inputs -> in_ready falls after 1 (L=1) or 2 (L=2) accepted entries.
//     Held out_result is stable. Then out_ready=1 -> entries drain in order with no loss or duplication.
//  5. flush asserted in the same cycle as an input transfer while 1 entry is buffered
//     -> next cycle busy=0, out_valid=0; neither entry is ever delivered; mul_count unchanged.
//  6. Preload mul_count to 0xFFFF via 65535 transfers, complete 1 more -> mul_count=0.
//     Assert reset_n=0 mid-stream -> all outputs 0 asynchronously, in_ready=1.

Source files
------------

// File: rtl/kernel_nios2_cpu_mul_combine.sv
// Combines the three registered 16x16 partial products into the low 32 bits of a*b.
// Define MUL_COMBINE_PIPE_EN to add an elastic stage A ahead of the output stage (latency 2).
module kernel_nios2_cpu_mul_combine #(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [CNT_W-1:0] mul_count
);

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [CNT_W-1:0] mul_count_q;

    logic             ready_b;
    logic             out_fire;
    logic             in_fire;
    logic             b_load;
    logic [31:0]      b_result_d;
    logic [TAG_W-1:0] b_tag_d;
    logic [15:0]      cross_in;

    // Upper halves of the cross products only affect bits above 31.
    logic unused_hi;
    assign unused_hi = ^{in_p2[31:16], in_p3[31:16]};

    assign cross_in = in_p2[15:0] + in_p3[15:0];
    assign ready_b  = ~out_valid_q | out_ready;
    assign out_fire = out_valid_q & out_ready;
    assign in_fire  = in_valid & in_ready;

`ifdef MUL_COMBINE_PIPE_EN
    logic             valid_a_q, valid_a_d;
    logic [15:0]      cross_a_q;
    logic [31:0]      p1_a_q;
    logic [TAG_W-1:0] tag_a_q;
    logic             a_fire;

    assign in_ready   = ~valid_a_q | ready_b;
    assign a_fire     = valid_a_q & ready_b;
    assign b_load     = a_fire;
    assign b_result_d = p1_a_q + {cross_a_q, 16'h0000};
    assign b_tag_d    = tag_a_q;
    assign busy       = valid_a_q | out_valid_q;

    assign valid_a_d = flush   ? 1'b0 :
                       in_fire ? 1'b1 :
                       a_fire  ? 1'b0 : valid_a_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_a_q <= 1'b0;
            cross_a_q <= '0;
            p1_a_q    <= '0;
            tag_a_q   <= '0;
        end else begin
            valid_a_q <= valid_a_d;
            if (in_fire) begin
                cross_a_q <= cross_in;
                p1_a_q    <= in_p1;
                tag_a_q   <= in_tag;
            end
        end
    end
`else
    assign in_ready   = ready_b;
    assign b_load     = in_fire;
    assign b_result_d = in_p1 + {cross_in, 16'h0000};
    assign b_tag_d    = in_tag;
    assign busy       = out_valid_q;
`endif

    // A load during an output transfer replaces the old entry, so load wins over drain.
    assign out_valid_d = flush    ? 1'b0 :
                         b_load   ? 1'b1 :
                         out_fire ? 1'b0 : out_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            mul_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (b_load) begin
                out_result_q <= b_result_d;
                out_tag_q    <= b_tag_d;
            end
            if (out_fire) begin
                mul_count_q <= mul_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign mul_count  = mul_count_q;

endmodule
